// File: rtl/seq_collect_pkg.sv
// seq_collect shared widths and FSM state encoding.
// Build option: SEQ_COLLECT_CHECK_EN enables the run-order check.
package seq_collect_pkg;

  localparam int DW = 11;
  localparam int CW = 12;
  localparam int SW = 23;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_collect_acc.sv
// Saturating beat counter, value sum and run-order error flag.
// Build option: SEQ_COLLECT_CHECK_EN keeps prev/compare logic.
module seq_collect_acc
  import seq_collect_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          add,
  input  logic [DW-1:0] data,
  output logic [CW-1:0] count,
  output logic [SW-1:0] sum,
  output logic          err
);

  logic [SW:0] sum_ext;

  assign sum_ext = {1'b0, sum} + (SW+1)'(data);

  // count/sum restart on a frame-opening zero, saturate on add
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      sum   <= '0;
    end else if (start) begin
      count <= CW'(1);
      sum   <= '0;
    end else if (add) begin
      if (count != '1)
        count <= count + CW'(1);
      sum <= sum_ext[SW] ? '1 : sum_ext[SW-1:0];
    end
  end

`ifdef SEQ_COLLECT_CHECK_EN
  logic [DW-1:0] prev;
  logic [DW:0]   want;

  // widened so prev=max never wraps onto a legal next value
  assign want = {1'b0, prev} + (DW+1)'(1);

  // sticky error when a beat breaks the 0,1,2,... run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err  <= 1'b0;
      prev <= '0;
    end else if (start) begin
      err  <= 1'b0;
      prev <= '0;
    end else if (add) begin
      err  <= err | ({1'b0, data} != want);
      prev <= data;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/seq_collect.sv
// Frame collector: zero-delimited beat runs summarised per frame.
// Build option: SEQ_COLLECT_CHECK_EN drives oerr from the run check.
module seq_collect
  import seq_collect_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          irdy,
  output logic          iack,
  input  logic [DW-1:0] idata,
  input  logic          iflush,
  output logic          ordy,
  input  logic          oack,
  output logic [CW-1:0] ocount,
  output logic [SW-1:0] osum,
  output logic          oerr
);

  state_t        state;
  logic          flush_pend;
  logic          zero;
  logic          open_f;
  logic          close_f;
  logic          add;
  logic          flush_go;
  logic          load;
  logic [CW-1:0] a_count;
  logic [SW-1:0] a_sum;
  logic          a_err;

  assign zero = (idata == '0);

  // a closing zero must wait until the output register is free
  assign iack = irdy &&
    !(ordy && zero && state == ACC);

  assign open_f   = iack && zero && state == IDLE;
  assign close_f  = iack && zero && state == ACC;
  assign add      = iack && !zero && state == ACC;
  assign flush_go = state == ACC && flush_pend &&
    !ordy && !iack;
  assign load     = close_f || flush_go;

  seq_collect_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .start (open_f || close_f),
    .add   (add),
    .data  (idata),
    .count (a_count),
    .sum   (a_sum),
    .err   (a_err)
  );

  // frame open/closed state and deferred flush request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          flush_pend <= 1'b0;
          if (open_f)
            state <= ACC;
        end
        ACC: begin
          if (flush_go) begin
            flush_pend <= 1'b0;
            state      <= IDLE;
          end else begin
            flush_pend <= flush_pend | iflush;
          end
        end
        default: begin
          state      <= IDLE;
          flush_pend <= 1'b0;
        end
      endcase
    end
  end

  // summary register: load on close/flush, free on oack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ordy   <= 1'b0;
      ocount <= '0;
      osum   <= '0;
    end else if (load) begin
      ordy   <= 1'b1;
      ocount <= a_count;
      osum   <= a_sum;
    end else if (ordy && oack) begin
      ordy <= 1'b0;
    end
  end

`ifdef SEQ_COLLECT_CHECK_EN
  // error flag travels with the summary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      oerr <= 1'b0;
    else if (load)
      oerr <= a_err;
  end
`else
  logic unused_err;
  assign unused_err = a_err;
  assign oerr = 1'b0;
`endif

endmodule

// File: tb/tb_seq_collect.sv
// Self-checking bench for seq_collect.
// Scoreboard of expected summaries, popped on each handshake.
module tb_seq_collect;
  import seq_collect_pkg::*;

`ifdef SEQ_COLLECT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          irdy = 1'b0;
  logic          iack;
  logic [DW-1:0] idata = '0;
  logic          iflush = 1'b0;
  logic          ordy;
  logic          oack = 1'b1;
  logic [CW-1:0] ocount;
  logic [SW-1:0] osum;
  logic          oerr;

  int n_chk = 0;
  int n_err = 0;

  logic [35:0] exp_q[$];
  logic [35:0] e;

  bit m_open = 1'b0;
  int m_cnt = 0;
  int m_sum = 0;
  bit m_err = 1'b0;
  int m_prev = 0;

  seq_collect dut (
    .clk    (clk),
    .rst    (rst),
    .irdy   (irdy),
    .iack   (iack),
    .idata  (idata),
    .iflush (iflush),
    .ordy   (ordy),
    .oack   (oack),
    .ocount (ocount),
    .osum   (osum),
    .oerr   (oerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic push_sum();
    logic [11:0] c;
    logic [22:0] s;
    c = 12'(m_cnt);
    s = 23'(m_sum);
    exp_q.push_back({c, s, m_err});
  endtask

  task automatic restart();
    m_open = 1'b1;
    m_cnt  = 1;
    m_sum  = 0;
    m_err  = 1'b0;
    m_prev = 0;
  endtask

  task automatic model_beat(input int d);
    if (!m_open) begin
      if (d == 0) restart();
    end else if (d != 0) begin
      if (m_cnt < 4095) m_cnt++;
      m_sum = m_sum + d;
      if (m_sum > 8388607) m_sum = 8388607;
      if (CHK && d != m_prev + 1) m_err = 1'b1;
      m_prev = d;
    end else begin
      push_sum();
      restart();
    end
  endtask

  task automatic model_flush();
    if (m_open) begin
      push_sum();
      m_open = 1'b0;
    end
  endtask

  task automatic send(input int d);
    int n;
    logic a;
    n = 0;
    a = 1'b0;
    irdy  = 1'b1;
    idata = DW'(d);
    while (!a && n < 100) begin
      @(negedge clk);
      a = iack;
      @(posedge clk);
      #1;
      n++;
    end
    irdy = 1'b0;
    if (!a) chk("send_timeout", 0, 1);
    else model_beat(d);
  endtask

  task automatic flush();
    iflush = 1'b1;
    @(posedge clk);
    #1;
    iflush = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_ordy", 32'(ordy), 32'(m_open));
    model_flush();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // consume and compare every summary handed over
  always @(negedge clk) begin
    if (rst && ordy && oack) begin
      if (exp_q.size() == 0) begin
        chk("spurious_summary", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ocount", 32'(ocount), 32'(e[35:24]));
        chk("osum", 32'(osum), 32'(e[23:1]));
        chk("oerr", 32'(oerr), 32'(e[0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_ordy", 32'(ordy), 0);
    chk("rst_ocount", 32'(ocount), 0);
    chk("rst_osum", 32'(osum), 0);
    chk("rst_oerr", 32'(oerr), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    irdy  = 1'b1;
    idata = 11'd5;
    @(negedge clk);
    chk("idle_iack", 32'(iack), 1);
    chk("idle_ordy", 32'(ordy), 0);
    @(posedge clk);
    #1;
    irdy = 1'b0;
    model_beat(5);

    send(0); send(1); send(2); send(3);
    send(0);
    chk("close_latency", 32'(ordy), 1);
    idle(2);

    send(1); send(3);
    flush();
    idle(2);
    send(5); send(0); send(1); send(0);
    idle(2);

    send(1);
    iflush = 1'b1;
    send(2);
    iflush = 1'b0;
    model_flush();
    idle(3);
    chk("flush_done", 32'(ordy), 0);

    oack = 1'b0;
    send(0); send(2); send(0);
    send(1);
    irdy  = 1'b1;
    idata = '0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_iack", 32'(iack), 0);
      chk("hold_ordy", 32'(ordy), 1);
      chk("hold_ocount", 32'(ocount), 2);
      @(posedge clk);
      #1;
    end
    oack = 1'b1;
    @(negedge clk);
    chk("stall_ack_cycle", 32'(iack), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_iack", 32'(iack), 1);
    @(posedge clk);
    #1;
    irdy = 1'b0;
    model_beat(0);
    chk("release_ordy", 32'(ordy), 1);
    idle(2);

    send(0);
    for (int i = 0; i < 4100; i++) send(2047);
    send(0);
    idle(2);

    oack = 1'b0;
    send(1); send(0);
    send(1); send(2);
    chk("pre_rst_ordy", 32'(ordy), 1);
    rst = 1'b0;
    #2;
    chk("arst_ordy", 32'(ordy), 0);
    chk("arst_ocount", 32'(ocount), 0);
    chk("arst_osum", 32'(osum), 0);
    chk("arst_oerr", 32'(oerr), 0);
    exp_q.delete();
    m_open = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b1;
    oack = 1'b1;
    send(7);
    send(0); send(1); send(0);
    idle(5);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seq_collect.md
SEQ_COLLECT -- requirements
Module: seq_collect

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port irdy, input, 1 bit: upstream beat valid.
REQ-004 SHALL have port iack, output, 1 bit: beat accepted this cycle; combinational, never asserted without irdy.
REQ-005 SHALL have port idata, input, 11 bits: beat value, unsigned.
REQ-006 SHALL have port iflush, input, 1 bit: single-cycle request to close the open frame.
REQ-007 SHALL have port ordy, output, 1 bit: summary valid, registered.
REQ-008 SHALL have port oack, input, 1 bit: summary consumed; meaningful only while ordy=1.
REQ-009 SHALL have port ocount, output, 12 bits: beats in the closed frame.
REQ-010 SHALL have port osum, output, 23 bits: sum of beat values in the closed frame.
REQ-011 SHALL have port oerr, output, 1 bit: frame was not a consecutive 0,1,2,... run.

Function
REQ-012 SHALL implement states IDLE (no frame open) and ACC (frame open); output register occupancy is tracked independently by ordy.
REQ-013 SHALL drive iack = irdy && !(ordy && idata==0 && state==ACC); all other beats are accepted the same cycle.
REQ-014 In IDLE, an accepted beat with idata==0 SHALL open a frame: count=1, sum=0, err=0, prev=0, go ACC.
REQ-015 In IDLE, an accepted beat with idata!=0 SHALL be discarded with no state change.
REQ-016 In ACC, an accepted beat with idata!=0 SHALL do count+=1 (saturate at 4095), sum+=idata (saturate at 2^23-1), err|=(idata!=prev+1), prev=idata.
REQ-017 In ACC, an accepted beat with idata==0 SHALL load {ocount,osum,oerr} from the accumulator, set ordy=1 on the next edge, and restart the accumulator as in REQ-014, staying in ACC.
REQ-018 iflush SHALL set a registered flush-pending flag; in IDLE the request and the pending flag SHALL be cleared.
REQ-019 In ACC with flush pending, ordy=0 and no beat accepted that cycle, the block SHALL emit the summary as in REQ-017, clear flush-pending and go IDLE.
REQ-020 A beat accepted in the same cycle as a pending flush SHALL be processed first; the flush remains pending and executes on a later cycle.
REQ-021 With ordy=1 and oack=1, ordy SHALL clear on the next edge; no new summary loads in that same cycle (one-cycle bubble minimum between summaries).
REQ-022 ocount/osum/oerr SHALL remain stable while ordy=1.
REQ-023 Summary latency SHALL be exactly one cycle: ordy rises on the edge that accepts the closing beat or performs the flush.

Reset
REQ-024 On rst=0: state=IDLE, ordy=0, ocount=0, osum=0, oerr=0, accumulator, prev and flush-pending cleared, asynchronously.
REQ-025 Reset mid-frame or with ordy=1 SHALL discard both the open frame and the pending summary.

Configuration
REQ-026 With SEQ_COLLECT_CHECK_EN defined, err/prev logic SHALL be compiled in per REQ-016.
REQ-027 Without SEQ_COLLECT_CHECK_EN, the prev register and compare SHALL be omitted and oerr SHALL be constant 0; all other behaviour unchanged.

Structure
REQ-028 Package seq_collect_pkg SHALL hold DW=11, CW=12, SW=23, and the state enum {IDLE, ACC}.
REQ-029 A sub-module seq_collect_acc SHALL hold the saturating count/sum/err accumulator; the top holds state, flush-pending and output registers.

Verification
REQ-030 Reset, irdy=1, idata=5 -> ordy=0, iack=1, beat discarded, state IDLE.
REQ-031 Beats 0,1,2,3 then 0 -> next cycle ordy=1, ocount=4, osum=6, oerr=0.
REQ-032 Beats 0,1,3 then iflush pulse -> ocount=3, osum=4, oerr=1 (0 without SEQ_COLLECT_CHECK_EN), state IDLE.
REQ-033 Summary held (oack=0), beats 0,1 then 0 -> iack=0 on the 0 until the cycle after oack, non-zero beats accepted meanwhile, second summary ocount=2, osum=1.
REQ-034 Beat 0 then 4100 beats of 2047, then 0 -> ocount=4095, osum=8388607, oerr=1.
REQ-035 rst pulled low after 0,1,2 with ordy=1 -> ordy=0, outputs 0; subsequent beat 7 discarded.
